// File: rtl/vertex_transform_sequencer.sv
// Vertex transform sequencer.
// Applies a locally held 4x4 fixed-point matrix to a buffer of 4-component
// vertices, using a single shared signed multiply-accumulator. Each vertex
// takes a 5-cycle fetch (LOAD) followed by a 16-cycle row-by-row MAC pass.
module vertex_transform_sequencer #(
  parameter int M      = 11,
  parameter int N      = 3,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [3:0]               cfg_addr,
  input  logic signed [M+N-1:0]    cfg_wr_data,
  input  logic [CNT_W-1:0]         num_vertices,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     vin_rd_en,
  output logic [ADDR_W-1:0]        vin_addr,
  input  logic signed [M+N-1:0]    vin_rd_data,
  output logic                     vout_wr_en,
  output logic [ADDR_W-1:0]        vout_addr,
  output logic signed [M-1:0]      vout_wr_data
);

  localparam int W      = M + N;
  localparam int PROD_W = 2 * W;
  localparam int ACC_W  = 2 * W + 3;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t                  state;
  logic signed [W-1:0]     mat  [16];
  logic signed [W-1:0]     vbuf [4];
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        v;
  logic [3:0]              cnt;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  row_sum;
  logic signed [ACC_W-1:0]  row_shift;
  logic [CNT_W-1:0]         v_next;
  logic [ADDR_W-1:0]        vbase;
  logic [ADDR_W-1:0]        vbase_next;
  logic [1:0]               load_idx;
  logic                     last_vertex;

  // MAC datapath: in MAC the phase counter equals 4*row+col, so it indexes the
  // matrix directly; the first column of a row restarts the sum instead of
  // adding to the previous row's total.
  always_comb begin
    prod        = PROD_W'(mat[cnt]) * PROD_W'(vbuf[cnt[1:0]]);
    prod_ext    = {{3{prod[PROD_W-1]}}, prod};
    row_sum     = (cnt[1:0] == 2'd0) ? prod_ext : acc + prod_ext;
    row_shift   = row_sum >>> (2 * N);
    v_next      = v + CNT_W'(1);
    vbase       = ADDR_W'({v, 2'b00});
    vbase_next  = ADDR_W'({v_next, 2'b00});
    load_idx    = cnt[1:0] - 2'd1;
    last_vertex = (v == count - CNT_W'(1));
  end

  // Sequencer FSM with registered memory-side and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      for (int i = 0; i < 16; i++) mat[i] <= '0;
      for (int i = 0; i < 4; i++) vbuf[i] <= '0;
      acc          <= '0;
      count        <= '0;
      v            <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vin_rd_en    <= 1'b0;
      vin_addr     <= '0;
      vout_wr_en   <= 1'b0;
      vout_addr    <= '0;
      vout_wr_data <= '0;
    end else begin
      vin_rd_en  <= 1'b0;
      vout_wr_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_wr_en) mat[cfg_addr] <= cfg_wr_data;
          if (start) begin
            count <= num_vertices;
            v     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (num_vertices == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= LOAD;
              vin_rd_en <= 1'b1;
              vin_addr  <= '0;
            end
          end
        end
        LOAD: begin
          if (cnt != 4'd0) vbuf[load_idx] <= vin_rd_data;
          if (cnt == 4'd4) begin
            state <= MAC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt < 4'd3) begin
              vin_rd_en <= 1'b1;
              vin_addr  <= vbase + ADDR_W'(cnt + 4'd1);
            end
          end
        end
        MAC: begin
          acc <= row_sum;
          cnt <= cnt + 4'd1;
          if (cnt[1:0] == 2'd3) begin
            vout_wr_en   <= 1'b1;
            vout_addr    <= vbase + ADDR_W'(cnt[3:2]);
            vout_wr_data <= row_shift[M-1:0];
          end
          if (cnt == 4'd15) begin
            v <= v_next;
            if (last_vertex) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= LOAD;
              vin_rd_en <= 1'b1;
              vin_addr  <= vbase_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
